alu_wb_queue: RTL and testbench
===============================

# alu_wb_queue

Writeback buffer directly downstream of the registered ALU: captures each ALU result (R, zero, ovf) plus its destination register tag, queues it in a small FIFO, and presents it to the register-file write port under a valid/ready handshake. It produces an issue-stall signal that covers the ALU's one-cycle latency, so no result is lost while the write port is busy. It also tracks overflow events for status and trap logic.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- WIDTH, 32, data width; matches ALU R
- TAG_W, 5, destination register tag width
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- alu_valid  input  1  ALU result is valid this cycle (issue valid delayed one cycle, aligned with R)
- alu_r  input  WIDTH  ALU result R
- alu_zero  input  1  ALU zero flag
- alu_ovf  input  1  ALU overflow flag
- alu_rd  input  TAG_W  destination tag, aligned with alu_r
- issue_stall  output  1  upstream must not issue an ALU op this cycle
- wb_valid  output  1  head entry valid
- wb_ready  input  1  write port accepts head entry
- wb_data  output  WIDTH  head result
- wb_rd  output  TAG_W  head destination tag
- wb_zero  output  1  head zero flag
- ovf_clear  input  1  clears ovf_sticky and ovf_count
- ovf_sticky  output  1  set on any accepted overflow result
- ovf_count  output  8  saturating overflow event count
- overrun  output  1  sticky: a push was lost on a full FIFO

## Operation
- Push: alu_valid=1 and alu_rd≠0. Results with alu_rd=0 are discarded (no write to register 0); their overflow is still counted.
- Pop: wb_valid=1 and wb_ready=1.
- Push on full: accepted only if a pop occurs the same cycle; otherwise dropped, overrun←1 (held until reset).
- Push and pop same cycle, non-full: count unchanged, order preserved.
- Read/write pointers are log2(DEPTH) bits, wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- issue_stall = (count ≥ DEPTH−1), decoded from the registered count: one result may already be in flight, so one slot is always reserved. In correct use, overrun never sets.
- Overflow event: alu_valid=1 and alu_ovf=1. ovf_count increments and saturates at 255; ovf_sticky←1.
- ovf_clear coincident with an event: the event wins; ovf_sticky=1 and ovf_count=1 afterwards.
- wb_data, wb_rd, and wb_zero are don't-care when wb_valid=0, but must be stable while wb_valid=1 and wb_ready=0.

## Timing
- Reset (asynchronous assert, synchronous release): FIFO empty. All outputs are 0: wb_valid, wb_data, wb_rd, wb_zero, issue_stall, ovf_sticky, ovf_count, overrun.
- Reset mid-operation discards all queued entries immediately.
- Latency: a push at edge N gives wb_valid=1 after edge N (visible in cycle N+1) when the FIFO was empty. There is no combinational in→out path.
- issue_stall updates one cycle after the count change that causes it.
- Throughput: one push and one pop per cycle.
- Status outputs update on the clock edge following the event.

## Configuration
- ALU_WB_OVF_TRAP_EN defined: results with alu_ovf=1 are not pushed (the destination is preserved, matching trap semantics); they are still counted and still set ovf_sticky.
- Undefined: overflowing results are pushed and written back like any other result; status tracking is unchanged.

## Test plan
- Reset during traffic: 3 entries queued, reset pulsed asynchronously between edges → all outputs 0 immediately; the first push after release appears on wb_data one cycle later.
- Ordering: push 0x11, 0x22, 0x33 (rd=1,2,3) with wb_ready=0, then wb_ready=1 → wb_data reads 0x11, 0x22, 0x33 on consecutive cycles; wb_zero matches each input.
- Stall reserve (DEPTH=4): push 3 entries with no pop → issue_stall=1 from the cycle after the 3rd push; 4th in-flight push accepted, count=4, overrun=0. 5th push with wb_ready=0 → dropped, overrun=1. 5th push with a simultaneous pop → accepted.
- rd=0: push 0xDEAD with rd=0 and ovf=1 → wb_valid stays 0; ovf_count=1; ovf_sticky=1.
- Overflow saturation/clear: 260 overflow events → ovf_count=255. ovf_clear together with an event → ovf_count=1, ovf_sticky=1. ovf_clear alone → both 0.
- Trap macro: with ALU_WB_OVF_TRAP_EN, push 0x80000000 with ovf=1, rd=4 → not queued, ovf_count increments. Without the macro → queued and presented on wb_data.

Source files
------------

// File: rtl/alu_wb_queue_if.sv
// ALU-result / register-file writeback bus for alu_wb_queue.
// The slave modport is the queue; the master modport is the surrounding pipeline.
interface alu_wb_queue_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic             alu_valid;
    logic [WIDTH-1:0] alu_r;
    logic             alu_zero;
    logic             alu_ovf;
    logic [TAG_W-1:0] alu_rd;
    logic             issue_stall;

    logic             wb_valid;
    logic             wb_ready;
    logic [WIDTH-1:0] wb_data;
    logic [TAG_W-1:0] wb_rd;
    logic             wb_zero;

    modport slave (
        input  alu_valid, alu_r, alu_zero, alu_ovf, alu_rd, wb_ready,
        output issue_stall, wb_valid, wb_data, wb_rd, wb_zero
    );

    modport master (
        output alu_valid, alu_r, alu_zero, alu_ovf, alu_rd, wb_ready,
        input  issue_stall, wb_valid, wb_data, wb_rd, wb_zero
    );
endinterface

// File: rtl/alu_wb_queue.sv
// Writeback FIFO between the registered ALU and the register-file write port,
// with issue stall, overrun flag and overflow statistics.
// Optional macro ALU_WB_OVF_TRAP_EN: overflowing results are counted but never queued.
module alu_wb_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_wb_queue_if.slave        bus,
    input  logic                 ovf_clear,
    output logic                 ovf_sticky,
    output logic [7:0]           ovf_count,
    output logic                 overrun
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] rd;
        logic             zero;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic               push_req;
    logic               push;
    logic               pop;
    logic               full;
    logic               ovf_event;
    entry_t             head;

    // Register 0 is never written; with trapping enabled the destination keeps its old value.
`ifdef ALU_WB_OVF_TRAP_EN
    assign push_req = bus.alu_valid && (bus.alu_rd != '0) && !bus.alu_ovf;
`else
    assign push_req = bus.alu_valid && (bus.alu_rd != '0);
`endif

    assign full      = (count == CNT_W'(DEPTH));
    assign pop       = bus.wb_valid && bus.wb_ready;
    assign push      = push_req && (!full || pop);
    assign ovf_event = bus.alu_valid && bus.alu_ovf;

    // One slot stays reserved for the result already in flight out of the ALU.
    assign bus.issue_stall = (count >= CNT_W'(DEPTH - 1));

    assign head         = mem[rd_ptr];
    assign bus.wb_valid = (count != '0);
    // Gated so the head fields read 0 while the queue is empty, including after reset.
    assign bus.wb_data  = bus.wb_valid ? head.data : '0;
    assign bus.wb_rd    = bus.wb_valid ? head.rd   : '0;
    assign bus.wb_zero  = bus.wb_valid ? head.zero : 1'b0;

    // NOTE: storage array has no reset; validity is tracked by count, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{data: bus.alu_r, rd: bus.alu_rd, zero: bus.alu_zero};
        end
    end

    // NOTE: all state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (push_req && full && !pop) begin
            overrun <= 1'b1;
        end
    end

    // An overflow event in the same cycle as a clear wins and restarts the count at 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_sticky <= 1'b0;
            ovf_count  <= '0;
        end else if (ovf_event) begin
            ovf_sticky <= 1'b1;
            if (ovf_clear) begin
                ovf_count <= 8'd1;
            end else if (ovf_count != 8'hFF) begin
                ovf_count <= ovf_count + 8'd1;
            end
        end else if (ovf_clear) begin
            ovf_sticky <= 1'b0;
            ovf_count  <= '0;
        end
    end
endmodule

// File: tb/tb_alu_wb_queue.sv
// Self-checking bench for alu_wb_queue: queue-based reference model compared every
// cycle, plus literal expectations for the directed scenarios.
module tb_alu_wb_queue;
    localparam int DEPTH = 4;
    localparam int WIDTH = 32;
    localparam int TAG_W = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ovf_clear;
    logic       ovf_sticky;
    logic [7:0] ovf_count;
    logic       overrun;

    int n_cmp = 0;
    int n_bad = 0;

    alu_wb_queue_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    alu_wb_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .ovf_clear  (ovf_clear),
        .ovf_sticky (ovf_sticky),
        .ovf_count  (ovf_count),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of results plus integer counters.
    typedef struct {
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] rd;
        logic             zero;
    } ent_t;

    ent_t m_q[$];
    int   m_ovf_cnt = 0;
    bit   m_sticky  = 0;
    bit   m_overrun = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_ovf_cnt = 0;
            m_sticky  = 0;
            m_overrun = 0;
        end else begin
            bit was_full;
            bit popping;
            bit wants;
            was_full = (m_q.size() == DEPTH);
            popping  = (m_q.size() > 0) && bus.wb_ready;
            wants    = bus.alu_valid && (bus.alu_rd != 0);
`ifdef ALU_WB_OVF_TRAP_EN
            if (bus.alu_ovf) wants = 0;
`endif
            if (popping) void'(m_q.pop_front());
            if (wants) begin
                if (!was_full || popping) m_q.push_back('{bus.alu_r, bus.alu_rd, bus.alu_zero});
                else m_overrun = 1;
            end
            if (bus.alu_valid && bus.alu_ovf) begin
                m_sticky  = 1;
                m_ovf_cnt = ovf_clear ? 1 : ((m_ovf_cnt < 255) ? m_ovf_cnt + 1 : 255);
            end else if (ovf_clear) begin
                m_sticky  = 0;
                m_ovf_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("wb_valid", 64'(bus.wb_valid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check("wb_data", 64'(bus.wb_data), 64'(m_q[0].data));
            check("wb_rd",   64'(bus.wb_rd),   64'(m_q[0].rd));
            check("wb_zero", 64'(bus.wb_zero), 64'(m_q[0].zero));
        end
        check("issue_stall", 64'(bus.issue_stall), 64'(m_q.size() >= DEPTH - 1));
        check("ovf_sticky",  64'(ovf_sticky), 64'(m_sticky));
        check("ovf_count",   64'(ovf_count),  64'(m_ovf_cnt));
        check("overrun",     64'(overrun),    64'(m_overrun));
    end

    // Apply one cycle of inputs; returns at the following falling edge.
    task automatic drive(input logic v, input logic [WIDTH-1:0] r, input logic [TAG_W-1:0] rd,
                         input logic z, input logic o, input logic rdy, input logic clr);
        bus.alu_valid = v;
        bus.alu_r     = r;
        bus.alu_rd    = rd;
        bus.alu_zero  = z;
        bus.alu_ovf   = o;
        bus.wb_ready  = rdy;
        ovf_clear     = clr;
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, '0, '0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},   64'(bus.wb_valid),    64'd0);
        check({tag, "_data"},    64'(bus.wb_data),     64'd0);
        check({tag, "_rd"},      64'(bus.wb_rd),       64'd0);
        check({tag, "_zero"},    64'(bus.wb_zero),     64'd0);
        check({tag, "_stall"},   64'(bus.issue_stall), 64'd0);
        check({tag, "_sticky"},  64'(ovf_sticky),      64'd0);
        check({tag, "_ovfcnt"},  64'(ovf_count),       64'd0);
        check({tag, "_overrun"}, 64'(overrun),         64'd0);
    endtask

    initial begin
        bus.alu_valid = 1'b0;
        bus.alu_r     = '0;
        bus.alu_rd    = '0;
        bus.alu_zero  = 1'b0;
        bus.alu_ovf   = 1'b0;
        bus.wb_ready  = 1'b0;
        ovf_clear     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Ordering with a blocked write port, then drain.
        drive(1'b1, 32'h11, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("first_latency", 64'(bus.wb_data), 64'h11);
        drive(1'b1, 32'h22, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h33, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ord_stall3", 64'(bus.issue_stall), 64'd1);
        check("ord_head0",  64'(bus.wb_data), 64'h11);
        idle(1'b1);
        check("ord_head1",  64'(bus.wb_data), 64'h22);
        check("ord_zero1",  64'(bus.wb_zero), 64'd1);
        idle(1'b1);
        check("ord_head2",  64'(bus.wb_data), 64'h33);
        check("ord_rd2",    64'(bus.wb_rd),   64'd3);
        idle(1'b1);
        check("ord_empty",  64'(bus.wb_valid), 64'd0);

        // Stall reserve, in-flight push, drop on full, push with pop on full.
        drive(1'b1, 32'hA1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hA2, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hA3, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        check("res_stall", 64'(bus.issue_stall), 64'd1);
        drive(1'b1, 32'hA4, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        check("res_inflight_ovr", 64'(overrun), 64'd0);
        drive(1'b1, 32'hA5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        check("res_drop_ovr", 64'(overrun), 64'd1);
        drive(1'b1, 32'hA6, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0);
        check("res_pushpop_head", 64'(bus.wb_data), 64'hA2);
        for (int i = 0; i < 4; i++) idle(1'b1);
        check("res_drained", 64'(bus.wb_valid), 64'd0);
        check("res_ovr_held", 64'(overrun), 64'd1);

        // Asynchronous reset between edges with three entries queued.
        drive(1'b1, 32'hB1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hB2, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'hB3, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.alu_valid = 1'b0;
        #2 reset = 1'b1;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 32'h55, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        check("post_rst_data", 64'(bus.wb_data), 64'h55);
        idle(1'b1);

        // Register 0 destination: discarded, overflow still counted.
        drive(1'b1, 32'hDEAD, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("rd0_valid",  64'(bus.wb_valid), 64'd0);
        check("rd0_ovfcnt", 64'(ovf_count),    64'd1);
        check("rd0_sticky", 64'(ovf_sticky),   64'd1);

        // Saturation, clear colliding with an event, clear alone.
        for (int i = 0; i < 260; i++) drive(1'b1, 32'(i), 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("sat_cnt", 64'(ovf_count), 64'd255);
        drive(1'b1, 32'h1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("clr_evt_cnt",    64'(ovf_count),  64'd1);
        check("clr_evt_sticky", 64'(ovf_sticky), 64'd1);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("clr_cnt",    64'(ovf_count),  64'd0);
        check("clr_sticky", 64'(ovf_sticky), 64'd0);

        // Overflowing result to a real register.
        drive(1'b1, 32'h8000_0000, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        check("trap_ovfcnt", 64'(ovf_count), 64'd1);
`ifdef ALU_WB_OVF_TRAP_EN
        check("trap_valid", 64'(bus.wb_valid), 64'd0);
`else
        check("trap_valid", 64'(bus.wb_valid), 64'd1);
        check("trap_data",  64'(bus.wb_data),  64'h8000_0000);
`endif
        idle(1'b1);

        // Back-to-back push and pop every cycle.
        for (int i = 0; i < 6; i++) drive(1'b1, 32'(i * 257 + 1), 5'(i + 1), 1'(i & 1), 1'b0, 1'b1, 1'b0);
        check("stream_stall", 64'(bus.issue_stall), 64'd0);
        idle(1'b1);
        idle(1'b1);
        check("stream_empty", 64'(bus.wb_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
